// File: rtl/uart_tx_controller.sv
// uart_tx_controller: UART transmit sequencer (start bit, LSB-first data, one stop bit)
// pulling bytes from a transmit buffer over a ready/read handshake.
module uart_tx_controller #(
  parameter int CLKS_PER_BIT  = 10,
  parameter int NUM_DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_data_ready,
  input  logic [7:0] tx_data,
  output logic       data_read,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TDONE = TW'(CLKS_PER_BIT - 2);
  localparam logic [3:0] BLAST = 4'(NUM_DATA_BITS - 1);
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic [3:0] bit_cnt;
  logic [NUM_DATA_BITS-1:0] shreg;
  // Outputs are flops loaded with the value for the state being entered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx_serial <= 1'b1;
      data_read <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_serial <= 1'b1;
          data_read <= tx_data_ready;
          tx_busy   <= tx_data_ready;
          if (tx_data_ready) state <= LOAD;
        end
        LOAD: begin
          shreg     <= tx_data[NUM_DATA_BITS-1:0];
          timer     <= '0;
          bit_cnt   <= '0;
          data_read <= 1'b0;
          tx_serial <= 1'b0;
          state     <= START;
        end
        START: begin
          if (timer == TMAX) begin
            timer     <= '0;
            tx_serial <= shreg[0];
            state     <= DATA;
          end else timer <= timer + 1'b1;
        end
        DATA: begin
          if (timer == TMAX) begin
            timer   <= '0;
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BLAST) begin
              tx_serial <= 1'b1;
              state     <= STOP;
            end else tx_serial <= shreg[1];
          end else timer <= timer + 1'b1;
        end
        STOP: begin
          if (timer == TMAX) begin
            timer     <= '0;
            tx_done   <= 1'b0;
            data_read <= tx_data_ready;
            tx_busy   <= tx_data_ready;
            state     <= tx_data_ready ? LOAD : IDLE;
          end else begin
            timer   <= timer + 1'b1;
            tx_done <= (timer == TDONE);
          end
        end
        default: begin
          state     <= IDLE;
          tx_serial <= 1'b1;
          data_read <= 1'b0;
          tx_busy   <= 1'b0;
          tx_done   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_controller.sv
// tb_uart_tx_controller: randomized self-checking bench; expected line levels come
// from a per-cycle frame model indexed by offset from the LOAD cycle.
module tb_uart_tx_controller;
  localparam int C  = 10;
  localparam int NB = 8;
  localparam int F  = C * (NB + 2);
  logic tb_clk = 1'b0;
  logic n_rst = 1'b1;
  logic tx_data_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic data_read, tx_serial, tx_busy, tx_done;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, reads = 0, exp_reads = 0, overlap = 0;

  uart_tx_controller #(.CLKS_PER_BIT(C), .NUM_DATA_BITS(NB)) dut (
    .clk(tb_clk), .n_rst(n_rst), .tx_data_ready(tx_data_ready), .tx_data(tx_data),
    .data_read(data_read), .tx_serial(tx_serial), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;
  always @(negedge tb_clk) begin
    if (data_read === 1'b1) reads <= reads + 1;
    if (data_read === 1'b1 && tx_done === 1'b1) overlap <= overlap + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Line level k cycles after LOAD: idle-high LOAD, C low, NB data bits of C cycles, C high.
  function automatic logic exp_line(input logic [7:0] d, input int k);
    if (k == 0 || k > C * (NB + 1)) return 1'b1;
    if (k <= C) return 1'b0;
    return d[(k - 1) / C - 1];
  endfunction

  task automatic start_frame(input logic [7:0] d);
    bit seen = 0;
    @(negedge tb_clk);
    tx_data_ready = 1'b1;
    tx_data = d;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge tb_clk);
      seen = (data_read === 1'b1);
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL start_frame: data_read got %b required 1 within 4 cycles", data_read);
    end
    exp_reads++;
  endtask

  // Entered at the negedge inside the LOAD cycle; leaves at the negedge of the last stop cycle.
  task automatic check_frame(input logic [7:0] d, input bit junk, input bit nxt, input logic [7:0] nd);
    for (int k = 0; k <= F; k++) begin
      if (k > 0) @(negedge tb_clk);
      n_tests += 4;
      if (tx_serial !== exp_line(d, k)) begin
        n_fail++;
        $display("FAIL line byte=%h k=%0d: got %b required %b", d, k, tx_serial, exp_line(d, k));
      end
      if (data_read !== (k == 0)) begin
        n_fail++;
        $display("FAIL data_read byte=%h k=%0d: got %b required %b", d, k, data_read, k == 0);
      end
      if (tx_done !== (k == F)) begin
        n_fail++;
        $display("FAIL tx_done byte=%h k=%0d: got %b required %b", d, k, tx_done, k == F);
      end
      if (tx_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL tx_busy byte=%h k=%0d: got %b required 1", d, k, tx_busy);
      end
      if (k == 0) tx_data_ready = 1'b0;
      if (junk) begin
        if (k == 3 * C) tx_data = 8'($urandom);
        tx_data_ready = (k == 2 || k == F - 3);
      end
      if (k == F) begin
        tx_data_ready = nxt;
        tx_data = nd;
      end
    end
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge tb_clk);
      n_tests++;
      if (tx_busy !== 1'b0 || tx_serial !== 1'b1 || data_read !== 1'b0 || tx_done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle cycle %0d: busy/serial/read/done got %b%b%b%b required 0100",
                 i, tx_busy, tx_serial, data_read, tx_done);
      end
    end
  endtask

  task automatic test_reset;
    #2 n_rst = 1'b0;
    #1;
    n_tests++;
    if ({tx_serial, data_read, tx_busy, tx_done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_immediate: got %b required 1000", {tx_serial, data_read, tx_busy, tx_done});
    end
    @(posedge tb_clk);
    #1;
    n_tests++;
    if ({tx_serial, data_read, tx_busy, tx_done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_hold: got %b required 1000", {tx_serial, data_read, tx_busy, tx_done});
    end
    @(negedge tb_clk);
    n_rst = 1'b1;
    check_idle(3);
  endtask

  task automatic test_single;
    start_frame(8'hA5);
    check_frame(8'hA5, 1'b1, 1'b0, 8'h00);
    check_idle(5);
    n_tests++;
    if (reads !== exp_reads) begin
      n_fail++;
      $display("FAIL single_read_count: got %0d required %0d", reads, exp_reads);
    end
  endtask

  task automatic test_data_change;
    start_frame(8'h5A);
    check_frame(8'h5A, 1'b1, 1'b0, 8'h3C);
    check_idle(3);
  endtask

  task automatic test_back_to_back;
    int t1, t2;
    start_frame(8'h00);
    t1 = cyc;
    check_frame(8'h00, 1'b0, 1'b1, 8'hFF);
    @(negedge tb_clk);
    t2 = cyc;
    exp_reads++;
    n_tests++;
    if (t2 - t1 !== F + 1) begin
      n_fail++;
      $display("FAIL b2b_period: got %0d required %0d", t2 - t1, F + 1);
    end
    check_frame(8'hFF, 1'b0, 1'b0, 8'h00);
    check_idle(3);
  endtask

  task automatic test_random_stream;
    logic [7:0] b [4];
    foreach (b[i]) b[i] = 8'($urandom);
    start_frame(b[0]);
    for (int i = 0; i < 4; i++) begin
      check_frame(b[i], 1'($urandom_range(0, 1)), i < 3, i < 3 ? b[i + 1] : 8'h00);
      if (i < 3) begin
        @(negedge tb_clk);
        exp_reads++;
      end
    end
    check_idle(3);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    int done_before;
    d = 8'($urandom) & 8'hF7;
    start_frame(d);
    tx_data_ready = 1'b0;
    for (int k = 1; k <= 1 + C * 4 + 4; k++) @(negedge tb_clk);
    n_tests++;
    if (tx_serial !== 1'b0) begin
      n_fail++;
      $display("FAIL bit3_level: got %b required 0", tx_serial);
    end
    #2 n_rst = 1'b0;
    #1;
    n_tests++;
    if ({tx_serial, data_read, tx_busy, tx_done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_mid_frame: got %b required 1000", {tx_serial, data_read, tx_busy, tx_done});
    end
    @(negedge tb_clk);
    n_rst = 1'b1;
    done_before = reads;
    check_idle(150);
    n_tests++;
    if (reads !== done_before) begin
      n_fail++;
      $display("FAIL reset_no_read: got %0d required %0d", reads, done_before);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_data_change;
    test_back_to_back;
    test_random_stream;
    test_reset_mid_frame;
    n_tests += 2;
    if (reads !== exp_reads) begin
      n_fail++;
      $display("FAIL total_reads: got %0d required %0d", reads, exp_reads);
    end
    if (overlap !== 0) begin
      n_fail++;
      $display("FAIL read_done_overlap: got %0d required 0", overlap);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
